// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes the 14-opcode ISA into a control bundle
// behind a valid/ready handshake, with load-use bubble insertion, flush and illegal-opcode trapping.
module decode_stage #(
  parameter int REG_AW    = 4,
  parameter int PC_W      = 8,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1,
  localparam int INSN_W   = 4 + 3*REG_AW,
  localparam int IMM_W    = 2*REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_op,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] dst,
  output logic [REG_AW-1:0] src0,
  output logic [REG_AW-1:0] src1,
  output logic [IMM_W-1:0]  data,
  output logic              reg_we,
  output logic              mem_we,
  output logic              reg0,
  output logic              reg1,
  output logic              jmp,
  output logic              cond,
  output logic              load,
  output logic              link,
  output logic              illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
    OP_CMP  = 4'h4, OP_ADDI = 4'h5, OP_SUBI = 4'h6, OP_CMPI = 4'h7,
    OP_LOAD = 4'h8, OP_STORE = 4'h9, OP_JMP = 4'hA, OP_JMPR = 4'hB,
    OP_JNZ  = 4'hC, OP_LI   = 4'hD
  } opcode_t;

  opcode_t           opc;
  logic [REG_AW-1:0] f2, f1, f0;

  assign opc = opcode_t'(in_op[INSN_W-1 -: 4]);
  assign f2  = in_op[3*REG_AW-1 : 2*REG_AW];
  assign f1  = in_op[2*REG_AW-1 : REG_AW];
  assign f0  = in_op[REG_AW-1 : 0];

  logic [REG_AW-1:0] d_dst, d_src0, d_src1;
  logic [IMM_W-1:0]  d_data;
  logic              d_reg_we, d_mem_we, d_reg0, d_reg1;
  logic              d_jmp, d_cond, d_load, d_link, d_illegal;

  // Decode the incoming instruction; anything not driven for an opcode stays zero.
  always_comb begin
    d_dst     = '0;
    d_src0    = '0;
    d_src1    = '0;
    d_data    = '0;
    d_reg_we  = 1'b0;
    d_mem_we  = 1'b0;
    d_reg0    = 1'b0;
    d_reg1    = 1'b0;
    d_jmp     = 1'b0;
    d_cond    = 1'b0;
    d_load    = 1'b0;
    d_link    = 1'b0;
    d_illegal = 1'b0;
    case (opc)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_CMP: begin
        d_src1 = f2;
        d_src0 = f1;
        d_reg1 = 1'b1;
        d_reg0 = 1'b1;
        if (opc != OP_CMP) begin
          d_dst    = f0;
          d_reg_we = 1'b1;
        end
      end
      OP_ADDI, OP_SUBI, OP_CMPI: begin
        d_src1 = f2;
        d_data = {f1, f0};
        d_reg1 = 1'b1;
        if (opc != OP_CMPI) begin
          d_dst    = f2;
          d_reg_we = 1'b1;
        end
      end
      OP_LOAD: begin
        d_src1   = f2;
        d_dst    = f0;
        d_data   = {{REG_AW{1'b0}}, f1};
        d_reg_we = 1'b1;
        d_reg1   = 1'b1;
        d_load   = 1'b1;
      end
      OP_STORE: begin
        d_src1   = f2;
        d_src0   = f1;
        d_data   = {{REG_AW{1'b0}}, f0};
        d_mem_we = 1'b1;
        d_reg1   = 1'b1;
      end
      OP_JMP: begin
        d_dst    = f0;
        d_data   = {f2, f1};
        d_reg_we = 1'b1;
        d_jmp    = 1'b1;
        d_link   = 1'b1;
      end
      OP_JMPR: begin
        d_src1   = f2;
        d_dst    = f0;
        d_data   = {{REG_AW{1'b0}}, f1};
        d_reg_we = 1'b1;
        d_reg1   = 1'b1;
        d_jmp    = 1'b1;
        d_link   = 1'b1;
      end
      OP_JNZ: begin
        d_dst    = f0;
        d_data   = {f2, f1};
        d_reg_we = 1'b1;
        d_link   = 1'b1;
        d_cond   = 1'b1;
      end
      OP_LI: begin
        d_dst    = f0;
        d_data   = {f2, f1};
        d_reg_we = 1'b1;
        d_reg1   = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // STORE reads its data register through src0 even though reg0 is clear.
  logic reads_held, hazard, advance, take;

  assign reads_held = (d_reg1 && (d_src1 == dst)) ||
                      ((d_reg0 || (opc == OP_STORE)) && (d_src0 == dst));
  assign hazard     = (HAZARD_EN != 0) && out_valid && load && in_valid && reads_held;
  assign advance    = !out_valid || out_ready;
  assign in_ready   = !flush && !hazard && advance;
  assign take       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      alu_op       <= '0;
      dst          <= '0;
      src0         <= '0;
      src1         <= '0;
      data         <= '0;
      reg_we       <= 1'b0;
      mem_we       <= 1'b0;
      reg0         <= 1'b0;
      reg1         <= 1'b0;
      jmp          <= 1'b0;
      cond         <= 1'b0;
      load         <= 1'b0;
      link         <= 1'b0;
      illegal      <= 1'b0;
      illegal_seen <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= take;
        if (take) begin
          out_pc  <= in_pc;
          alu_op  <= in_op[INSN_W-1 -: 4];
          dst     <= d_dst;
          src0    <= d_src0;
          src1    <= d_src1;
          data    <= d_data;
          reg_we  <= d_reg_we;
          mem_we  <= d_mem_we;
          reg0    <= d_reg0;
          reg1    <= d_reg1;
          jmp     <= d_jmp;
          cond    <= d_cond;
          load    <= d_load;
          link    <= d_link;
          illegal <= d_illegal;
        end
      end
      if (take && d_illegal)
        illegal_seen <= 1'b1;
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage between fetch and execute.
- Decodes the 14-opcode ISA into the same control bundle as the combinational decoder, with field widths generalised by REG_AW.
- Adds a valid/ready handshake, a load-use hazard bubble, flush, illegal-opcode trapping and a stall counter.
- Branch condition (zf) is resolved downstream; decode only flags conditional jumps.

Parameters:
REG_AW, 4, register address width; INSN_W = 4+3*REG_AW, IMM_W = 2*REG_AW (derived, not overridable)
PC_W, 8, program-counter width
CNT_W, 16, stall counter width
HAZARD_EN, 1, 1 = load-use bubble insertion enabled; 0 = never stall

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of stage contents (taken jump downstream)
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_op  in  INSN_W  instruction; op[INSN_W-1-:4]=opcode, F2=[3RA-1:2RA], F1=[2RA-1:RA], F0=[RA-1:0]
in_pc  in  PC_W  PC of instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  PC_W  registered PC
alu_op  out  4  opcode passthrough
dst, src0, src1  out  REG_AW each  register addresses
data  out  IMM_W  immediate
reg_we, mem_we, reg0, reg1, jmp, cond, load, link  out  1 each  control bits
illegal  out  1  bundle came from undefined opcode
illegal_seen  out  1  sticky; set on first accepted illegal opcode
stall_cnt  out  CNT_W  saturating count of hazard-bubble cycles

Behaviour:
- Opcodes: AND=0, OR=1, ADD=2, SUB=3, CMP=4, ADDI=5, SUBI=6, CMPI=7, LOAD=8, STORE=9, JMP=A, JMPR=B, JNZ=C, LI=D; E, F illegal.
- Short imm = zero-extended F1. Long imm = {F2,F1}.
- ALU ops 0-3: src1=F2, src0=F1, dst=F0, reg_we, reg1 and reg0 set.
- CMP: as ALU ops but dst=0 and reg_we=0.
- ADDI/SUBI: src1=dst=F2, data=long-low {F1,F0}, reg_we and reg1 set.
- CMPI: same as ADDI/SUBI but dst=0 and reg_we=0.
- LOAD: src1=F2, dst=F0, data=short imm; reg_we, reg1 and load set.
- STORE: src1=F2, src0=F1, data=zero-extended F0; mem_we and reg1 set.
- JMP: dst=F0, data=long imm; reg_we, jmp and link set.
- JMPR: src1=F2, dst=F0, data=short imm; reg_we, reg1, jmp and link set.
- JNZ: dst=F0, data=long imm; reg_we, link and cond set, jmp=0. Execute gates jmp/link/reg_we with zf.
- LI: dst=F0, data=long imm; reg_we and reg1 set.
- Any field not listed for an opcode is 0.
- Illegal opcode: all enables 0, illegal=1, fields 0. illegal_seen stays set until reset.
- Reset (async): out_valid, all bundle outputs, illegal, illegal_seen and stall_cnt go to 0. Reset mid-stream discards the held bundle.
- Output register accepts new data when empty or when out_ready is high this cycle.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- A transfer on the input (in_valid && in_ready) gives out_valid=1 next cycle. Latency is 1 cycle.
- While out_valid && !out_ready, every output holds stable.
- Hazard: HAZARD_EN && out_valid && load && in_valid, and the incoming instruction reads the held dst:
  - reads src1 when its reg1=1;
  - reads src0 when its reg0=1 or it is a STORE.
- On a hazard, in_ready=0. If out_ready, the next out_valid is 0 (one bubble); the instruction is accepted the following cycle.
- stall_cnt increments by 1 for each cycle with a hazard and a pending in_valid, saturating at all-ones.
- flush: out_valid goes to 0 next cycle and the input is not accepted that cycle. Flush has priority over hazard and transfer. illegal_seen and stall_cnt are unaffected.
- Throughput: 1 instruction per cycle when there are no hazards and out_ready=1.

Test Plan:
- Reset released, in_valid=1, in_op=0x2345, out_ready=1 -> next cycle out_valid=1, alu_op=2, src1=3, src0=4, dst=5, reg_we=reg0=reg1=1, out_pc equals in_pc.
- 0x8123 (LOAD r1 imm2 -> r3) then 0x2345 back-to-back -> LOAD bundle (load=1, data=0x02, dst=3), then one out_valid=0 cycle, then ADD bundle; stall_cnt=1. Repeat with HAZARD_EN=0 -> no bubble.
- 0x8123 then 0x9330 (STORE r3 -> [r3+0]) -> bubble inserted. 0x8123 then 0xD7F4 (LI) -> no bubble.
- 0xC5A2 -> jmp=0, cond=1, link=1, reg_we=1, dst=2, data=0x5A. 0xA5A2 -> jmp=1, cond=0.
- 0xE000 -> illegal=1, reg_we=mem_we=0, illegal_seen=1 persisting across 0x2345; rst_n low mid-stream -> everything 0 immediately.
- out_ready=0 for 3 cycles with a bundle held -> outputs stable and in_ready=0. flush asserted with in_valid -> out_valid=0 next cycle and the incoming op is dropped.
